// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder
// Responder side of the instruction-fetch interface. A fetch address is
// accepted with a valid/ready handshake, the synchronous instruction RAM is
// read in the accept cycle, and the instruction comes back tagged with its
// address one cycle later. Accepted fetches sit in a one-deep in-flight stage
// (the cycle the RAM read completes) and then in a 2-entry response buffer.
// A redirect flush drops every fetch not yet handed to the consumer. A
// program-load port writes the RAM independently of the fetch handshake.
//
// The response head is the oldest accepted fetch: the buffer head when the
// buffer holds anything, otherwise the in-flight entry, whose instruction is
// taken straight from the RAM output register. This gives accept-to-valid
// latency of one cycle with no combinational path from req_* to rsp_*.

module imem_fetch_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h400,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,

    input  logic        flush,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [31:0] rsp_addr,
    output logic        rsp_fault,

    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    // One past the last valid byte address, kept 33 bits wide so the limit
    // itself cannot wrap when the window ends at the top of the address map.
    localparam logic [32:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

    // An address is unusable when misaligned or outside the RAM window. The
    // compare is on the full address, so anything below BASE_ADDR faults
    // rather than wrapping around into the array.
    function automatic logic addr_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < BASE_ADDR) || ({1'b0, a} >= ADDR_LIMIT);
    endfunction

    // Word index inside the RAM; only meaningful for addresses that do not fault.
    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    // ---------------------------------------------------------------------
    // Storage
    // ---------------------------------------------------------------------
    logic [31:0]      mem [DEPTH_WORDS];
    logic [31:0]      ram_q;

    // In-flight stage: accepted last cycle, RAM data now in ram_q.
    logic             infl_valid;
    logic [31:0]      infl_addr;
    logic             infl_fault;

    // Response buffer, two entries, circular.
    logic [31:0]      fifo_addr  [2];
    logic [31:0]      fifo_instr [2];
    logic             fifo_fault [2];
    logic [1:0]       fifo_count;
    logic             wr_ptr;
    logic             rd_ptr;

    // ---------------------------------------------------------------------
    // Control signals
    // ---------------------------------------------------------------------
    logic [1:0]       occupancy;
    logic             req_fault;
    logic             accept;
    logic             rd_en;
    logic             wr_en;
    logic             head_valid;
    logic             pop;
    logic             pop_fifo;
    logic             push;
    logic [31:0]      infl_instr;

    logic [31:0]      head_addr;
    logic [31:0]      head_instr;
    logic             head_fault;

    // Handshake, RAM enables and buffer push/pop decisions for this cycle.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path (these are
        // all unconditional); a missed branch would otherwise infer a latch.
        occupancy  = fifo_count + {1'b0, infl_valid};
        req_ready  = !rst && !flush && (occupancy < 2'd2);
        req_fault  = addr_fault(req_addr);
        accept     = req_valid && req_ready;
        rd_en      = accept && !req_fault;
        wr_en      = load_en && !addr_fault(load_addr);

        head_valid = (fifo_count != 2'd0) || infl_valid;
        pop        = head_valid && rsp_ready;
        // A pop with an empty buffer consumes the in-flight entry directly,
        // so that entry is never written into the buffer.
        pop_fifo   = pop && (fifo_count != 2'd0);
        push       = infl_valid && !(pop && (fifo_count == 2'd0));
    end

    // Response head: oldest accepted fetch, zeroed whenever nothing is valid.
    always_comb begin
        infl_instr = infl_fault ? 32'h0 : ram_q;
        head_addr  = infl_addr;
        head_instr = infl_instr;
        head_fault = infl_fault;
        if (fifo_count != 2'd0) begin
            head_addr  = fifo_addr[rd_ptr];
            head_instr = fifo_instr[rd_ptr];
            head_fault = fifo_fault[rd_ptr];
        end

        rsp_valid = head_valid;
        rsp_addr  = head_valid ? head_addr  : 32'h0;
        rsp_instr = head_valid ? head_instr : 32'h0;
        rsp_fault = head_valid && head_fault;
    end

    // Instruction RAM: synchronous read on accept, program-load write.
    // NOTE: the array and its output register carry no reset; RAM contents
    // survive rst and ram_q is only observed behind infl_valid.
    always_ff @(posedge clk) begin
        // Both updates are non-blocking, so a same-word read and write in one
        // cycle returns the old word (read-first).
        if (rd_en) begin
            ram_q <= mem[addr_idx(req_addr)];
        end
        if (wr_en) begin
            mem[addr_idx(load_addr)] <= load_data;
        end
    end

    // Occupancy state: in-flight flag, buffer count and pointers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples values from before this edge.
        if (rst || flush) begin
            infl_valid <= 1'b0;
            fifo_count <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
        end else begin
            infl_valid <= accept;
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop_fifo};
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_fifo) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // In-flight payload: address and fault status of the accepted fetch.
    always_ff @(posedge clk) begin
        if (accept) begin
            infl_addr  <= req_addr;
            infl_fault <= req_fault;
        end
    end

    // Buffer payload: capture the in-flight entry, including its RAM word,
    // before ram_q can be overwritten by the next read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr]  <= infl_addr;
            fifo_instr[wr_ptr] <= infl_instr;
            fifo_fault[wr_ptr] <= infl_fault;
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb_imem_fetch_responder
// Drives one cycle of inputs at a time and compares the outputs against a
// reference model: a queue of accepted-but-unconsumed responses plus a word
// array for the RAM. Directed scenarios run first, then random traffic.

module tb_imem_fetch_responder;

    localparam logic [31:0] BASE  = 32'h400;
    localparam int          DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_fault;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    imem_fetch_responder #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_fault (rsp_fault),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        fault;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] mem_m [DEPTH];
    int          total = 0;
    int          bad   = 0;
    bit          after_rst = 1'b0;

    function automatic bit is_bad_addr(input logic [31:0] a);
        longint ua;
        ua = longint'(a);
        return (a[1:0] != 2'b00) || (ua < longint'(BASE)) || (ua >= longint'(BASE) + 4 * DEPTH);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, compare outputs, advance the model.
    task automatic step(input bit rv, input logic [31:0] ra, input bit rr, input bit fl,
                        input bit le, input logic [31:0] la, input logic [31:0] ld,
                        input bit rs);
        rsp_t e;
        bit   exp_valid;
        bit   exp_ready;
        bit   acc;
        bit   pop;
        @(negedge clk);
        rst       = rs;
        req_valid = rv;
        req_addr  = ra;
        rsp_ready = rr;
        flush     = fl;
        load_en   = le;
        load_addr = la;
        load_data = ld;
        #1;
        exp_valid = exp_q.size() > 0;
        exp_ready = !rs && !fl && (exp_q.size() < 2);
        check("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
        check("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_valid});
        if (exp_valid) begin
            check("rsp_instr", rsp_instr, exp_q[0].instr);
            check("rsp_addr",  rsp_addr,  exp_q[0].addr);
            check("rsp_fault", {31'b0, rsp_fault}, {31'b0, exp_q[0].fault});
        end else if (after_rst) begin
            check("rst_instr", rsp_instr, 32'h0);
            check("rst_addr",  rsp_addr,  32'h0);
            check("rst_fault", {31'b0, rsp_fault}, 32'h0);
        end
        after_rst = rs;

        acc = rv && exp_ready;
        pop = exp_valid && rr;
        e.addr  = ra;
        e.fault = is_bad_addr(ra);
        e.instr = e.fault ? 32'h0 : mem_m[word_of(ra)];
        if (rs || fl) begin
            exp_q.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(e);
        end
        // Load applied after the fetch lookup: same-cycle fetch sees old data.
        if (le && !is_bad_addr(la)) mem_m[word_of(la)] = ld;
    endtask

    task automatic idle(input bit rr);
        step(1'b0, 32'h0, rr, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic fetch(input logic [31:0] a, input bit rr);
        step(1'b1, a, rr, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, a, d, 1'b0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0:       a = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
            1:       a = $urandom_range(0, BASE - 1);
            2:       a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 255);
            3:       a = 32'hFFFF_FFFC - 4 * $urandom_range(0, 3);
            4:       a = BASE + 4 * (DEPTH - 1);
            default: a = BASE + 4 * $urandom_range(0, DEPTH - 1);
        endcase
        return a;
    endfunction

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; rsp_ready = 1'b0;
        flush = 1'b0; load_en = 1'b0; load_addr = 32'h0; load_data = 32'h0;

        // Reset, then check the reset state.
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle(1'b0);

        // Fill the whole RAM so every in-range fetch has known data.
        for (int i = 0; i < DEPTH; i++) load(BASE + 32'(4 * i), $urandom);
        load(32'h400, 32'h2402_000A);
        load(32'h404, 32'h0000_0000);

        // Single fetch, one-cycle latency.
        fetch(32'h400, 1'b1);
        idle(1'b1);

        // Back-to-back stream.
        fetch(32'h400, 1'b1);
        fetch(32'h404, 1'b1);
        fetch(32'h408, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Backpressure: only two accepted, outputs held, then drain.
        for (int i = 0; i < 4; i++) fetch(32'h40C + 32'(4 * i), 1'b0);
        idle(1'b0);
        idle(1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Faulting addresses, then a good one.
        fetch(32'h402, 1'b1);
        fetch(32'h3FC, 1'b1);
        fetch(BASE + 4 * DEPTH, 1'b1);
        fetch(32'hFFFF_FFFC, 1'b1);
        fetch(32'h400, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush with two entries buffered and a request pending.
        fetch(32'h400, 1'b0);
        fetch(32'h404, 1'b0);
        idle(1'b0);
        step(1'b1, 32'h408, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        fetch(32'h40C, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Same-cycle load and fetch of one word: old data, then new.
        step(1'b1, 32'h400, 1'b1, 1'b0, 1'b1, 32'h400, 32'hDEAD_BEEF, 1'b0);
        idle(1'b1);
        fetch(32'h400, 1'b1);
        idle(1'b1);

        // Reset in the middle of a stream.
        fetch(32'h404, 1'b0);
        fetch(32'h408, 1'b0);
        step(1'b1, 32'h40C, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle(1'b1);
        fetch(32'h410, 1'b1);
        idle(1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit rs;
            rs = ($urandom_range(0, 99) == 0);
            step($urandom_range(0, 9) < 7, rand_addr(), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 99) < 3, !rs && ($urandom_range(0, 99) < 15),
                 rand_addr(), $urandom, rs);
        end
        idle(1'b1);
        idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
